fp_sqrt_iter: RTL and testbench

- Multi-cycle, parametrised IEEE-754 square-root unit. Covers any binary format via EXP_W/MAN_W; default is fp32.
- Uses a radix-2 digit recurrence that retires DPC root bits per cycle, so one shared datapath replaces an unrolled array.
- Accepts operands on a valid/ready input port and returns the result, exception flags and a passthrough tag on a valid/ready output port.
- Supports five run-time rounding modes. Sits in the FP execute cluster next to the divider.

---
 rtl/fp_sqrt_iter.sv | 233 +++++++++++++++++++++++
 tb/tb_fp_sqrt_iter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: multi-cycle IEEE-754 square root. A restoring radix-2 digit
// recurrence retires DPC root bits per cycle on one shared datapath; special
// operands bypass the recurrence and complete on the accept edge.
module fp_sqrt_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned DPC   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [2:0]           in_rm,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_y,
    output logic                 out_nv,
    output logic                 out_nx,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned R     = MAN_W + 2;          // leading 1, fraction, guard
    localparam int unsigned REM_W = R + 4;              // headroom for the <<2 before compare
    localparam int unsigned CNT_W = $clog2(R + 1);
    localparam int unsigned LZ_W  = $clog2(MAN_W + 2);
    localparam int unsigned EW    = EXP_W + LZ_W + 2;   // signed unbiased exponent
    localparam logic [CNT_W-1:0]     R_CNT = CNT_W'(R);
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StNorm, StIter, StRound, StDone} state_t;

    state_t             state_q, state_d;
    logic [W-2:0]       ef_q;
    logic [2:0]         rm_q;
    logic [TAG_W-1:0]   tag_q;
    logic [W-1:0]       y_q;
    logic               nv_q, nx_q;
    logic [2*R-1:0]     rad_q, rad_n;
    logic [REM_W-1:0]   rem_q, rem_n;
    logic [R-1:0]       root_q, root_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [EXP_W-1:0]   exp_q;

    logic               accept;
    logic               in_special, spec_nv;
    logic [W-1:0]       spec_y;
    logic               is_nan, is_zero, is_inf;
    logic [EXP_W-1:0]   in_exp, a_exp;
    logic [MAN_W-1:0]   in_frac, a_frac;

    assign in_exp  = in_a[W-2:MAN_W];
    assign in_frac = in_a[MAN_W-1:0];
    assign a_exp   = ef_q[W-2:MAN_W];
    assign a_frac  = ef_q[MAN_W-1:0];
    assign accept  = in_valid & in_ready;

    // Classify the incoming operand and form its immediate result if special
    always_comb begin
        is_nan     = (&in_exp) & (|in_frac);
        is_inf     = (&in_exp) & ~(|in_frac);
        is_zero    = ~(|in_exp) & ~(|in_frac);
        in_special = is_nan | is_inf | is_zero | in_a[W-1];
        spec_y     = in_a;
        spec_nv    = 1'b0;
        if (is_nan) begin
            spec_y  = QNAN;
            spec_nv = ~in_frac[MAN_W-1];
        end else if (!is_zero && in_a[W-1]) begin
            spec_y  = QNAN;
            spec_nv = 1'b1;
        end
    end

    logic [LZ_W-1:0]      lz;
    logic [MAN_W:0]       sig;
    logic [R-1:0]         mant_in;
    logic signed [EW-1:0] e_unb, e_even;
    logic [EXP_W-1:0]     exp_norm;

    // Normalise the captured operand: significand, even exponent, result exponent
    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < MAN_W; i++) begin
            if (a_frac[i]) lz = LZ_W'(MAN_W - i);
        end
        if (a_exp != '0) begin
            sig   = {1'b1, a_frac};
            e_unb = $signed({{(EW - EXP_W){1'b0}}, a_exp}) - BIAS;
        end else begin
            sig   = {1'b0, a_frac} << lz;
            e_unb = $signed({{(EW - 1){1'b0}}, 1'b1}) - BIAS
                    - $signed({{(EW - LZ_W){1'b0}}, lz});
        end
        // Odd exponent: double the significand so the halved exponent is exact
        mant_in  = e_unb[0] ? {sig, 1'b0} : {1'b0, sig};
        e_even   = {e_unb[EW-1:1], 1'b0};
        exp_norm = EXP_W'({e_even[EW-1], e_even[EW-1:1]} + BIAS);
    end

    logic [REM_W-1:0] shifted, trial;

    // One ITER cycle: up to DPC restoring steps; steps past R are suppressed
    always_comb begin
        rad_n   = rad_q;
        rem_n   = rem_q;
        root_n  = root_q;
        cnt_n   = cnt_q;
        shifted = '0;
        trial   = '0;
        for (int unsigned j = 0; j < DPC; j++) begin
            if (cnt_n < R_CNT) begin
                shifted = {rem_n[REM_W-3:0], rad_n[2*R-1 -: 2]};
                trial   = {2'b00, root_n, 2'b01};
                rad_n   = rad_n << 2;
                if (shifted >= trial) begin
                    rem_n  = shifted - trial;
                    root_n = {root_n[R-2:0], 1'b1};
                end else begin
                    rem_n  = shifted;
                    root_n = {root_n[R-2:0], 1'b0};
                end
                cnt_n = cnt_n + CNT_W'(1);
            end
        end
    end

    logic             g_bit, l_bit, s_bit, up;
    logic [MAN_W:0]   mant_rnd;
    logic [W-1:0]     round_y;

    // Round the positive root; a carry-out leaves frac=0 and bumps the exponent
    always_comb begin
        g_bit = root_q[0];
        l_bit = root_q[1];
        s_bit = |rem_q;
        case (rm_q)
            3'b001, 3'b010: up = 1'b0;
            3'b011:         up = g_bit | s_bit;
            3'b100:         up = g_bit;
            default:        up = g_bit & (l_bit | s_bit);
        endcase
        mant_rnd = {1'b0, root_q[R-2:1]} + {{MAN_W{1'b0}}, up};
        round_y  = {1'b0, exp_q + EXP_W'(mant_rnd[MAN_W]), mant_rnd[MAN_W-1:0]};
    end

    // Next-state and input handshake decode
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = in_special ? StDone : StNorm;
            end
            StNorm:  state_d = StIter;
            StIter:  if (cnt_n == R_CNT) state_d = StRound;
            StRound: state_d = StDone;
            StDone: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? (in_special ? StDone : StNorm) : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Operand capture, recurrence registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ef_q   <= '0;
            rm_q   <= '0;
            tag_q  <= '0;
            y_q    <= '0;
            nv_q   <= 1'b0;
            nx_q   <= 1'b0;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            exp_q  <= '0;
        end else begin
            if (accept) begin
                ef_q  <= in_a[W-2:0];
                rm_q  <= in_rm;
                tag_q <= in_tag;
                if (in_special) begin
                    y_q  <= spec_y;
                    nv_q <= spec_nv;
                    nx_q <= 1'b0;
                end
            end
            case (state_q)
                StNorm: begin
                    rad_q  <= {mant_in, {R{1'b0}}};
                    rem_q  <= '0;
                    root_q <= '0;
                    cnt_q  <= '0;
                    exp_q  <= exp_norm;
                end
                StIter: begin
                    rad_q  <= rad_n;
                    rem_q  <= rem_n;
                    root_q <= root_n;
                    cnt_q  <= cnt_n;
                end
                StRound: begin
                    y_q  <= round_y;
                    nv_q <= 1'b0;
                    nx_q <= g_bit | s_bit;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_y     = y_q;
    assign out_nv    = nv_q;
    assign out_nx    = nx_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: directed vectors for fp_sqrt_iter (fp32, DPC=1 and DPC=4).
// Latency is counted as rising edges after the accept edge until out_valid.
module tb_fp_sqrt_iter;
    localparam int LAT1 = 27;   // NORM + 25 ITER + ROUND
    localparam int LAT4 = 9;    // NORM + 7 ITER + ROUND

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_a = '0, out_y;
    logic [2:0]  in_rm = '0;
    logic [3:0]  in_tag = '0, out_tag;
    logic        out_nv, out_nx;

    logic        v4 = 1'b0, rdy4, ov4, ordy4 = 1'b0, nv4, nx4;
    logic [31:0] a4 = '0, y4;
    logic [2:0]  rm4 = '0;
    logic [3:0]  tag4 = '0, t4;

    int n_checks = 0;
    int n_fails  = 0;

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .DPC(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_rm(in_rm), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_nv(out_nv), .out_nx(out_nx), .out_tag(out_tag)
    );

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .DPC(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_a(a4),
        .in_rm(rm4), .in_tag(tag4), .out_valid(ov4), .out_ready(ordy4),
        .out_y(y4), .out_nv(nv4), .out_nx(nx4), .out_tag(t4)
    );

    always #5 clk = ~clk;

    localparam int NS = 9;
    localparam logic [31:0] SPEC_A [NS] = '{32'hBF800000, 32'h7F800001, 32'hFFC00000,
        32'h80000000, 32'h7F800000, 32'h00000000, 32'hFF800000, 32'h80000001, 32'h7FC00001};
    localparam logic [31:0] SPEC_Y [NS] = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
        32'h80000000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000};
    localparam logic SPEC_NV [NS] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    localparam int NN = 8;
    localparam logic [31:0] NORM_A [NN] = '{32'h40800000, 32'h41100000, 32'h3F800000,
        32'h00800000, 32'h7F7FFFFF, 32'h00000001, 32'h00200000, 32'h00400000};
    localparam logic [31:0] NORM_Y [NN] = '{32'h40000000, 32'h40400000, 32'h3F800000,
        32'h20000000, 32'h5F7FFFFF, 32'h1A3504F3, 32'h1F800000, 32'h1FB504F3};
    localparam logic NORM_NX [NN] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    localparam int NR = 16;
    localparam logic [31:0] RND_A [NR] = '{32'h40000000, 32'h40000000, 32'h40000000,
        32'h40000000, 32'h40000000, 32'h40000000, 32'h40A00000, 32'h40A00000, 32'h40A00000,
        32'h40A00000, 32'h40A00000, 32'h407FFFFF, 32'h407FFFFF, 32'h407FFFFF, 32'h407FFFFF,
        32'h7F7FFFFF};
    localparam logic [2:0] RND_RM [NR] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd3, 3'd4, 3'd3};
    localparam logic [31:0] RND_Y [NR] = '{32'h3FB504F3, 32'h3FB504F3, 32'h3FB504F3,
        32'h3FB504F4, 32'h3FB504F3, 32'h3FB504F3, 32'h400F1BBD, 32'h400F1BBC, 32'h400F1BBC,
        32'h400F1BBD, 32'h400F1BBD, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h40000000, 32'h3FFFFFFF,
        32'h5F800000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand to the DPC=1 unit while it is idle
    task automatic issue(input logic [31:0] a, input logic [2:0] rm, input logic [3:0] tag);
        in_a = a;
        in_rm = rm;
        in_tag = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid; -1 if the budget runs out
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_y !== 32'h0 || out_nv !== 1'b0 || out_nx !== 1'b0
            || out_tag !== 4'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: valid=%b y=%h nv=%b nx=%b tag=%h, want all zero",
                     out_valid, out_y, out_nv, out_nx, out_tag);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_specials();
        int lat;
        for (int i = 0; i < NS; i++) begin
            issue(SPEC_A[i], 3'd0, 4'(i));
            wait_valid(lat);
            n_checks++;
            if (lat !== 0) begin
                n_fails++;
                $display("FAIL special[%0d] latency: got %0d want 0", i, lat);
            end
            n_checks++;
            if (out_y !== SPEC_Y[i] || out_nv !== SPEC_NV[i] || out_nx !== 1'b0
                || out_tag !== 4'(i)) begin
                n_fails++;
                $display("FAIL special[%0d] a=%h: got y=%h nv=%b nx=%b tag=%h want y=%h nv=%b nx=0 tag=%h",
                         i, SPEC_A[i], out_y, out_nv, out_nx, out_tag, SPEC_Y[i], SPEC_NV[i], 4'(i));
            end
            drain();
        end
    endtask

    task automatic test_normal();
        int lat;
        for (int i = 0; i < NN; i++) begin
            issue(NORM_A[i], 3'd0, 4'(i + 3));
            wait_valid(lat);
            n_checks++;
            if (lat !== LAT1) begin
                n_fails++;
                $display("FAIL normal[%0d] latency: got %0d want %0d", i, lat, LAT1);
            end
            n_checks++;
            if (out_y !== NORM_Y[i] || out_nx !== NORM_NX[i] || out_nv !== 1'b0
                || out_tag !== 4'(i + 3)) begin
                n_fails++;
                $display("FAIL normal[%0d] a=%h: got y=%h nx=%b nv=%b tag=%h want y=%h nx=%b nv=0 tag=%h",
                         i, NORM_A[i], out_y, out_nx, out_nv, out_tag, NORM_Y[i], NORM_NX[i], 4'(i + 3));
            end
            drain();
        end
    endtask

    task automatic test_rounding();
        int lat;
        for (int i = 0; i < NR; i++) begin
            issue(RND_A[i], RND_RM[i], 4'hA);
            wait_valid(lat);
            n_checks++;
            if (out_y !== RND_Y[i] || out_nx !== 1'b1 || out_nv !== 1'b0) begin
                n_fails++;
                $display("FAIL round[%0d] a=%h rm=%0d: got y=%h nx=%b nv=%b want y=%h nx=1 nv=0",
                         i, RND_A[i], RND_RM[i], out_y, out_nx, out_nv, RND_Y[i]);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        bit  stable;
        issue(32'h40800000, 3'd0, 4'd3);
        wait_valid(lat);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== 32'h40000000
                || out_tag !== 4'd3) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fails++;
            $display("FAIL backpressure_hold: valid=%b ready=%b y=%h tag=%h want 1 0 40000000 3",
                     out_valid, in_ready, out_y, out_tag);
        end
        in_a = 32'h41100000;
        in_rm = 3'd0;
        in_tag = 4'd5;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL done_accept_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL done_accept_valid_drop: got %b want 0", out_valid);
        end
        wait_valid(lat);
        n_checks++;
        if (lat !== LAT1 || out_y !== 32'h40400000 || out_tag !== 4'd5) begin
            n_fails++;
            $display("FAIL back_to_back_result: lat=%0d y=%h tag=%h want %0d 40400000 5",
                     lat, out_y, out_tag, LAT1);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit stale;
        issue(32'h40000000, 3'd0, 4'd7);
        repeat (10) tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_op_busy: valid=%b ready=%b want 0 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_op_reset_valid: got %b want 0", out_valid);
        end
        #2 rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_op_ready_after_release: got %b want 1", in_ready);
        end
        stale = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fails++;
            $display("FAIL mid_op_stale_result: out_valid rose with y=%h tag=%h", out_y, out_tag);
        end
        issue(32'h41100000, 3'd0, 4'd9);
        wait_valid(lat);
        n_checks++;
        if (out_y !== 32'h40400000 || out_tag !== 4'd9 || out_nx !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_op_next: y=%h tag=%h nx=%b want 40400000 9 0", out_y, out_tag, out_nx);
        end
        drain();
    endtask

    task automatic test_dpc4();
        logic [31:0] va [4] = '{32'h40800000, 32'h40000000, 32'h40A00000, 32'h407FFFFF};
        logic [2:0]  vr [4] = '{3'd0, 3'd3, 3'd1, 3'd3};
        logic [31:0] vy [4] = '{32'h40000000, 32'h3FB504F4, 32'h400F1BBC, 32'h40000000};
        logic        vx [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            a4 = va[i];
            rm4 = vr[i];
            tag4 = 4'(i + 1);
            v4 = 1'b1;
            tick();
            v4 = 1'b0;
            lat = 0;
            while (!ov4 && lat < 200) begin
                tick();
                lat++;
            end
            n_checks++;
            if (lat !== LAT4) begin
                n_fails++;
                $display("FAIL dpc4[%0d] latency: got %0d want %0d", i, lat, LAT4);
            end
            n_checks++;
            if (y4 !== vy[i] || nx4 !== vx[i] || nv4 !== 1'b0 || t4 !== 4'(i + 1)) begin
                n_fails++;
                $display("FAIL dpc4[%0d] a=%h: got y=%h nx=%b nv=%b tag=%h want y=%h nx=%b nv=0 tag=%h",
                         i, va[i], y4, nx4, nv4, t4, vy[i], vx[i], 4'(i + 1));
            end
            ordy4 = 1'b1;
            tick();
            ordy4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_specials();
        test_normal();
        test_rounding();
        test_back_to_back();
        test_reset_mid_op();
        test_dpc4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
